// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the 5-stage MIPS datapath.
// Captures the fetched instruction and PC+4 on every edge. Holds them for a
// load-use stall against the instruction in ID. Replaces the fetched word
// with a NOP when a branch is taken. Keeps saturating stall and flush
// counters for debug.
module if_id_stage #(
   parameter logic [31:0] NOP    = 32'h00000000,
   parameter int          CONT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       instrucaoIF,
   input  logic [31:0]       pcMais4IF,
   input  logic              idexMemRead,
   input  logic [4:0]        idexRt,
   input  logic              branchTomado,
   output logic [31:0]       instrucaoID,
   output logic [31:0]       pcMais4ID,
   output logic              validoID,
   output logic              PCescreve,
   output logic              bolha,
   output logic [CONT_W-1:0] contaStall,
   output logic [CONT_W-1:0] contaFlush
);

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CONT_W-1:0] sat_inc(input logic [CONT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [31:0]       r_instr;
   logic [31:0]       r_pc4;
   logic              r_valid;
   logic [CONT_W-1:0] r_stall_cnt;
   logic [CONT_W-1:0] r_flush_cnt;

   logic [4:0]        w_rs;
   logic [4:0]        w_rt;
   logic              w_rt_hit;
   logic              w_haz;

   // Source fields of the instruction in ID. Both are compared regardless of
   // opcode, which may stall an instruction that does not read rt. That costs
   // one cycle and never misses a real hazard.
   assign w_rs = r_instr[25:21];
   assign w_rt = r_instr[20:16];

   // $zero can never carry a load result, so a load targeting it is harmless.
   // A squashed slot is not a real consumer even if its fields happen to match.
   assign w_rt_hit = (idexRt == w_rs) || (idexRt == w_rt);
   assign w_haz    = r_valid && idexMemRead && (idexRt != 5'd0) && w_rt_hit;

   // Pipeline register: a flush outranks a stall, and a stall outranks a normal capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_instr <= NOP;
         r_pc4   <= 32'h0;
         r_valid <= 1'b0;
      end else if (branchTomado) begin
         r_instr <= NOP;
         r_pc4   <= pcMais4IF;
         r_valid <= 1'b0;
      end else if (!w_haz) begin
         r_instr <= instrucaoIF;
         r_pc4   <= pcMais4IF;
         r_valid <= 1'b1;
      end
   end

   // Debug event counters. A flush that coincides with a hazard counts only as a flush.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (branchTomado) begin
         r_flush_cnt <= sat_inc(r_flush_cnt);
      end else if (w_haz) begin
         r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

   // A taken branch must let the PC move to its target even while a hazard is
   // visible, because the hazarding instruction is being squashed anyway.
   assign PCescreve   = ~w_haz | branchTomado;
   assign bolha       = w_haz & ~branchTomado;

   assign instrucaoID = r_instr;
   assign pcMais4ID   = r_pc4;
   assign validoID    = r_valid;
   assign contaStall  = r_stall_cnt;
   assign contaFlush  = r_flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage.
// It runs a table of directed vectors, then multi-cycle corner sequences,
// then a randomized run compared against a behavioural model.
module tb_if_id_stage;

   localparam int CW      = 16;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clock;
   logic          reset;
   logic [31:0]   instrucaoIF;
   logic [31:0]   pcMais4IF;
   logic          idexMemRead;
   logic [4:0]    idexRt;
   logic          branchTomado;
   logic [31:0]   instrucaoID;
   logic [31:0]   pcMais4ID;
   logic          validoID;
   logic          PCescreve;
   logic          bolha;
   logic [CW-1:0] contaStall;
   logic [CW-1:0] contaFlush;

   int n_checks = 0;
   int n_fail   = 0;

   if_id_stage #(.NOP(32'h00000000), .CONT_W(CW)) dut (
      .clock(clock), .reset(reset),
      .instrucaoIF(instrucaoIF), .pcMais4IF(pcMais4IF),
      .idexMemRead(idexMemRead), .idexRt(idexRt), .branchTomado(branchTomado),
      .instrucaoID(instrucaoID), .pcMais4ID(pcMais4ID), .validoID(validoID),
      .PCescreve(PCescreve), .bolha(bolha),
      .contaStall(contaStall), .contaFlush(contaFlush)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural reference: the architectural content of the IF/ID slot and
   // the event totals.
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic        m_valid;
   int          m_stall;
   int          m_flush;

   task automatic model_reset();
      m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_stall = 0; m_flush = 0;
   endtask

   // The slot consumes a register that a load in ID/EX has not produced yet.
   function automatic logic model_haz();
      int src_a, src_b;
      src_a = int'(m_instr[25:21]);
      src_b = int'(m_instr[20:16]);
      if (!m_valid || !idexMemRead || idexRt == 5'd0) return 1'b0;
      return (int'(idexRt) == src_a) || (int'(idexRt) == src_b);
   endfunction

   task automatic model_edge();
      if (branchTomado) begin
         m_instr = 32'h0; m_pc = pcMais4IF; m_valid = 1'b0;
         if (m_flush < CNT_MAX) m_flush = m_flush + 1;
      end else if (model_haz()) begin
         if (m_stall < CNT_MAX) m_stall = m_stall + 1;
      end else begin
         m_instr = instrucaoIF; m_pc = pcMais4IF; m_valid = 1'b1;
      end
   endtask

   typedef struct {
      logic [31:0] instr_if;
      logic [31:0] pc_if;
      logic        mem_rd;
      logic [4:0]  rt;
      logic        br;
      logic        exp_pcw;    // before the edge
      logic        exp_bolha;  // before the edge
      logic [31:0] exp_instr;  // after the edge
      logic [31:0] exp_pc;
      logic        exp_valid;
      int          exp_stall;
      int          exp_flush;
   } vec_t;

   vec_t vecs[10];

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                        input logic mr, input logic [4:0] rt, input logic br);
      instrucaoIF = ins; pcMais4IF = pc; idexMemRead = mr; idexRt = rt; branchTomado = br;
   endtask

   initial begin
      vecs[0] = '{32'h8C080004, 32'h04, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h8C080004, 32'h04, 1'b1, 0, 0};
      vecs[1] = '{32'h01095020, 32'h08, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h01095020, 32'h08, 1'b1, 0, 0};
      vecs[2] = '{32'hAAAA0000, 32'h0C, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 32'h01095020, 32'h08, 1'b1, 1, 0};
      vecs[3] = '{32'hAAAA0000, 32'h0C, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0, 32'hAAAA0000, 32'h0C, 1'b1, 1, 0};
      vecs[4] = '{32'h00095020, 32'h10, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h00095020, 32'h10, 1'b1, 1, 0};
      vecs[5] = '{32'h11111111, 32'h14, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h11111111, 32'h14, 1'b1, 1, 0};
      vecs[6] = '{32'h22222222, 32'h18, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h18, 1'b0, 1, 1};
      vecs[7] = '{32'h01095020, 32'h1C, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 32'h01095020, 32'h1C, 1'b1, 1, 1};
      vecs[8] = '{32'h33333333, 32'h20, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 32'h01095020, 32'h1C, 1'b1, 2, 1};
      vecs[9] = '{32'h44444444, 32'h24, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h24, 1'b0, 2, 2};

      // Reset is asserted before any clock edge.
      reset = 1'b1;
      drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      #1;
      check("rst_instr", instrucaoID, 32'h0);
      check("rst_pc", pcMais4ID, 32'h0);
      check("rst_valid", {31'b0, validoID}, 32'h0);
      check("rst_pcw", {31'b0, PCescreve}, 32'h1);
      check("rst_bolha", {31'b0, bolha}, 32'h0);
      check("rst_stall", {16'b0, contaStall}, 32'h0);
      check("rst_flush", {16'b0, contaFlush}, 32'h0);
      #1 reset = 1'b0;

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].instr_if, vecs[i].pc_if, vecs[i].mem_rd, vecs[i].rt, vecs[i].br);
         #1;
         check($sformatf("v%0d_pcw", i), {31'b0, PCescreve}, {31'b0, vecs[i].exp_pcw});
         check($sformatf("v%0d_bolha", i), {31'b0, bolha}, {31'b0, vecs[i].exp_bolha});
         @(posedge clock); #1;
         check($sformatf("v%0d_instr", i), instrucaoID, vecs[i].exp_instr);
         check($sformatf("v%0d_pc", i), pcMais4ID, vecs[i].exp_pc);
         check($sformatf("v%0d_valid", i), {31'b0, validoID}, {31'b0, vecs[i].exp_valid});
         check($sformatf("v%0d_stall", i), {16'b0, contaStall}, vecs[i].exp_stall);
         check($sformatf("v%0d_flush", i), {16'b0, contaFlush}, vecs[i].exp_flush);
      end

      // Async reset raised between edges during a stall.
      drive(32'h01095020, 32'h30, 1'b0, 5'd0, 1'b0);
      @(posedge clock); #1;
      drive(32'h66666666, 32'h34, 1'b1, 5'd8, 1'b0);
      #1;
      check("ars_pcw_stall", {31'b0, PCescreve}, 32'h0);
      #2 reset = 1'b1;
      #1;
      check("ars_instr", instrucaoID, 32'h0);
      check("ars_pc", pcMais4ID, 32'h0);
      check("ars_valid", {31'b0, validoID}, 32'h0);
      check("ars_pcw", {31'b0, PCescreve}, 32'h1);
      check("ars_bolha", {31'b0, bolha}, 32'h0);
      check("ars_stall", {16'b0, contaStall}, 32'h0);
      check("ars_flush", {16'b0, contaFlush}, 32'h0);
      #1 reset = 1'b0;
      drive(32'h55555555, 32'h40, 1'b1, 5'd8, 1'b0);
      @(posedge clock); #1;
      check("ars_cap_instr", instrucaoID, 32'h55555555);
      check("ars_cap_valid", {31'b0, validoID}, 32'h1);

      // Stall counter saturation: a hazard held for 2^16+5 edges.
      reset = 1'b1; #1 reset = 1'b0;
      drive(32'h01095020, 32'h50, 1'b0, 5'd0, 1'b0);
      @(posedge clock); #1;
      drive(32'h77777777, 32'h54, 1'b1, 5'd8, 1'b0);
      for (int k = 0; k < (1 << CW) + 5; k++) @(posedge clock);
      #1;
      check("sat_stall", {16'b0, contaStall}, 32'h0000FFFF);
      check("sat_instr_held", instrucaoID, 32'h01095020);
      check("sat_pcw", {31'b0, PCescreve}, 32'h0);
      check("sat_flush", {16'b0, contaFlush}, 32'h0);

      // Randomized run against the behavioural model.
      reset = 1'b1; #1 reset = 1'b0;
      model_reset();
      for (int c = 0; c < 2000; c++) begin
         logic [31:0] ins;
         ins = $urandom;
         ins[25:21] = 5'($urandom_range(0, 3));
         ins[20:16] = 5'($urandom_range(0, 3));
         drive(ins, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0));
         #1;
         check("rnd_pcw", {31'b0, PCescreve}, {31'b0, (~model_haz() | branchTomado)});
         check("rnd_bolha", {31'b0, bolha}, {31'b0, (model_haz() & ~branchTomado)});
         if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1; #1;
            model_reset();
            check("rnd_rst_valid", {31'b0, validoID}, 32'h0);
            reset = 1'b0;
         end else begin
            model_edge();
            @(posedge clock); #1;
            check("rnd_instr", instrucaoID, m_instr);
            check("rnd_pc", pcMais4ID, m_pc);
            check("rnd_valid", {31'b0, validoID}, {31'b0, m_valid});
            check("rnd_stall", {16'b0, contaStall}, m_stall);
            check("rnd_flush", {16'b0, contaFlush}, m_flush);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
